// File: rtl/press_counter.sv
`default_nettype none
// ============================================================================
//  Module      : press_counter
//  Description : BCD up/down counter driven by two debounced press detectors.
//                Each request is acknowledged with a one-cycle handshake so
//                every physical press moves the count exactly once.
//  Revision    : 1.0  initial release
// ============================================================================
module press_counter #(
    parameter int DIGITS      = 4,
    parameter int RESET_VALUE = 0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  incPressed,
    input  logic                  decPressed,
    input  logic                  clear,
    output logic                  ackInc,
    output logic                  ackDec,
    output logic [4*DIGITS-1:0]   count,
    output logic                  wrapped
);

    localparam int c_W = 4 * DIGITS;

    // Binary-to-BCD conversion of the reset constant, evaluated at elaboration.
    function automatic logic [c_W-1:0] f_to_bcd(input int unsigned value);
        logic [c_W-1:0] bcd;
        int unsigned    rest;
        bcd  = '0;
        rest = value;
        for (int i = 0; i < DIGITS; i++) begin
            bcd[4*i +: 4] = 4'(rest % 10);
            rest          = rest / 10;
        end
        return bcd;
    endfunction

    localparam logic [c_W-1:0] c_RESET_BCD = f_to_bcd(RESET_VALUE);

    // Handshake states
    localparam logic [1:0] c_IDLE     = 2'd0;
    localparam logic [1:0] c_ACK      = 2'd1;
    localparam logic [1:0] c_WAIT_CLR = 2'd2;

    logic [1:0]     r_state;
    logic           r_pend_inc;
    logic           r_pend_dec;
    logic           r_ack_inc;
    logic           r_ack_dec;
    logic [c_W-1:0] r_count;
    logic           r_wrapped;

    logic [c_W-1:0] w_inc_count;
    logic           w_inc_carry;
    logic [c_W-1:0] w_dec_count;
    logic           w_dec_borrow;
    logic [c_W-1:0] w_count_nxt;
    logic           w_wrap_nxt;
    logic           w_take;
    logic           w_still_pending;

    assign w_take          = incPressed | decPressed;
    assign w_still_pending = (r_pend_inc & incPressed) | (r_pend_dec & decPressed);

    // Ripple BCD increment; the carry surviving the top digit is the wrap flag.
    // Digits at 9 or above roll to 0 so a corrupt digit can never persist.
    always_comb begin
        w_inc_count = r_count;
        w_inc_carry = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (w_inc_carry) begin
                if (r_count[4*i +: 4] >= 4'd9) begin
                    w_inc_count[4*i +: 4] = 4'd0;
                end else begin
                    w_inc_count[4*i +: 4] = r_count[4*i +: 4] + 4'd1;
                    w_inc_carry           = 1'b0;
                end
            end
        end
    end

    // Ripple BCD decrement; a borrow out of the top digit is the wrap flag.
    always_comb begin
        w_dec_count  = r_count;
        w_dec_borrow = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (w_dec_borrow) begin
                if (r_count[4*i +: 4] == 4'd0) begin
                    w_dec_count[4*i +: 4] = 4'd9;
                end else begin
                    w_dec_count[4*i +: 4] = (r_count[4*i +: 4] > 4'd9) ? 4'd9
                                          : r_count[4*i +: 4] - 4'd1;
                    w_dec_borrow          = 1'b0;
                end
            end
        end
    end

    // Next count: clear wins over any update; simultaneous inc+dec cancel out.
    always_comb begin
        w_count_nxt = r_count;
        w_wrap_nxt  = 1'b0;
        if (clear) begin
            w_count_nxt = c_RESET_BCD;
        end else if ((r_state == c_IDLE) && w_take) begin
            if (incPressed && !decPressed) begin
                w_count_nxt = w_inc_count;
                w_wrap_nxt  = w_inc_carry;
            end else if (decPressed && !incPressed) begin
                w_count_nxt = w_dec_count;
                w_wrap_nxt  = w_dec_borrow;
            end
        end
    end

    // Handshake FSM with registered acknowledge outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state    <= c_IDLE;
            r_pend_inc <= 1'b0;
            r_pend_dec <= 1'b0;
            r_ack_inc  <= 1'b0;
            r_ack_dec  <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_take) begin
                        r_state    <= c_ACK;
                        r_pend_inc <= incPressed;
                        r_pend_dec <= decPressed;
                        r_ack_inc  <= incPressed;
                        r_ack_dec  <= decPressed;
                    end
                end
                c_ACK: begin
                    r_state   <= c_WAIT_CLR;
                    r_ack_inc <= 1'b0;
                    r_ack_dec <= 1'b0;
                end
                c_WAIT_CLR: begin
                    // Stay until the detectors we acknowledged have let go.
                    if (!w_still_pending) begin
                        r_state <= c_IDLE;
                    end
                end
                default: begin
                    r_state   <= c_IDLE;
                    r_ack_inc <= 1'b0;
                    r_ack_dec <= 1'b0;
                end
            endcase
        end
    end

    // Count and wrap registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_count   <= c_RESET_BCD;
            r_wrapped <= 1'b0;
        end else begin
            r_count   <= w_count_nxt;
            r_wrapped <= w_wrap_nxt;
        end
    end

    assign ackInc  = r_ack_inc;
    assign ackDec  = r_ack_dec;
    assign count   = r_count;
    assign wrapped = r_wrapped;

endmodule
`default_nettype wire

// File: tb/tb_press_counter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_press_counter
//  Description : Self-checking bench for press_counter (DIGITS=4).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_press_counter;

    logic        clock;
    logic        reset;
    logic        incPressed;
    logic        decPressed;
    logic        clear;
    logic        ackInc;
    logic        ackDec;
    logic [15:0] count;
    logic        wrapped;

    int n_vec;
    int n_miss;
    int m_count;
    int ack_pulses;

    press_counter #(.DIGITS(4), .RESET_VALUE(0)) dut (
        .clock      (clock),
        .reset      (reset),
        .incPressed (incPressed),
        .decPressed (decPressed),
        .clear      (clear),
        .ackInc     (ackInc),
        .ackDec     (ackDec),
        .count      (count),
        .wrapped    (wrapped)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        inc;
        logic        dec;
        logic        clr;
        logic [15:0] exp_count;
        logic        exp_ai;
        logic        exp_ad;
        logic        exp_w;
    } vec_t;

    vec_t vecs[28];

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        r[3:0]   = 4'(v % 10);
        r[7:4]   = 4'((v / 10) % 10);
        r[11:8]  = 4'((v / 100) % 10);
        r[15:12] = 4'((v / 1000) % 10);
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set_vec(input int i, input logic inc, input logic dec, input logic clr,
                           input logic [15:0] c, input logic ai, input logic ad, input logic w);
        vecs[i].inc       = inc;
        vecs[i].dec       = dec;
        vecs[i].clr       = clr;
        vecs[i].exp_count = c;
        vecs[i].exp_ai    = ai;
        vecs[i].exp_ad    = ad;
        vecs[i].exp_w     = w;
    endtask

    // One full press with a detector that drops its request once it sees ack.
    // Entered and left on a falling edge with the DUT idle.
    task automatic press(input logic inc, input logic dec);
        int  old;
        logic w_exp;
        old   = m_count;
        w_exp = 1'b0;
        if (inc && !dec) begin
            m_count = (m_count + 1) % 10000;
            w_exp   = (old == 9999);
        end else if (dec && !inc) begin
            m_count = (m_count + 9999) % 10000;
            w_exp   = (old == 0);
        end
        incPressed = inc;
        decPressed = dec;
        @(posedge clock);
        @(negedge clock);
        chk("press ackInc", 32'(ackInc), 32'(inc));
        chk("press ackDec", 32'(ackDec), 32'(dec));
        chk("press count", 32'(count), 32'(to_bcd(m_count)));
        chk("press wrapped", 32'(wrapped), 32'(w_exp));
        if (ackInc) ack_pulses++;
        incPressed = 1'b0;
        decPressed = 1'b0;
        @(posedge clock);
        @(negedge clock);
        chk("ack width", 32'({ackInc, ackDec, wrapped}), 32'd0);
        @(posedge clock);
        @(negedge clock);
    endtask

    initial begin
        n_vec      = 0;
        n_miss     = 0;
        m_count    = 0;
        ack_pulses = 0;
        incPressed = 1'b0;
        decPressed = 1'b0;
        clear      = 1'b0;
        reset      = 1'b1;

        //          idx inc  dec  clr  count    ai   ad   w
        set_vec( 0, 1'b0,1'b0,1'b0,16'h0000,1'b0,1'b0,1'b0);
        set_vec( 1, 1'b1,1'b0,1'b0,16'h0001,1'b1,1'b0,1'b0);
        set_vec( 2, 1'b1,1'b0,1'b0,16'h0001,1'b0,1'b0,1'b0);
        set_vec( 3, 1'b0,1'b0,1'b0,16'h0001,1'b0,1'b0,1'b0);
        set_vec( 4, 1'b0,1'b1,1'b0,16'h0000,1'b0,1'b1,1'b0);
        set_vec( 5, 1'b0,1'b1,1'b0,16'h0000,1'b0,1'b0,1'b0);
        set_vec( 6, 1'b0,1'b0,1'b0,16'h0000,1'b0,1'b0,1'b0);
        set_vec( 7, 1'b0,1'b1,1'b0,16'h9999,1'b0,1'b1,1'b1);
        set_vec( 8, 1'b0,1'b1,1'b0,16'h9999,1'b0,1'b0,1'b0);
        set_vec( 9, 1'b0,1'b0,1'b0,16'h9999,1'b0,1'b0,1'b0);
        set_vec(10, 1'b1,1'b0,1'b0,16'h0000,1'b1,1'b0,1'b1);
        set_vec(11, 1'b1,1'b0,1'b0,16'h0000,1'b0,1'b0,1'b0);
        set_vec(12, 1'b1,1'b0,1'b0,16'h0000,1'b0,1'b0,1'b0);
        set_vec(13, 1'b1,1'b0,1'b0,16'h0000,1'b0,1'b0,1'b0);
        set_vec(14, 1'b0,1'b0,1'b0,16'h0000,1'b0,1'b0,1'b0);
        set_vec(15, 1'b1,1'b1,1'b0,16'h0000,1'b1,1'b1,1'b0);
        set_vec(16, 1'b1,1'b1,1'b0,16'h0000,1'b0,1'b0,1'b0);
        set_vec(17, 1'b0,1'b0,1'b0,16'h0000,1'b0,1'b0,1'b0);
        set_vec(18, 1'b1,1'b0,1'b0,16'h0001,1'b1,1'b0,1'b0);
        set_vec(19, 1'b1,1'b0,1'b1,16'h0000,1'b0,1'b0,1'b0);
        set_vec(20, 1'b0,1'b0,1'b0,16'h0000,1'b0,1'b0,1'b0);
        set_vec(21, 1'b1,1'b0,1'b0,16'h0001,1'b1,1'b0,1'b0);
        set_vec(22, 1'b1,1'b1,1'b0,16'h0001,1'b0,1'b0,1'b0);
        set_vec(23, 1'b0,1'b1,1'b0,16'h0001,1'b0,1'b0,1'b0);
        set_vec(24, 1'b0,1'b1,1'b0,16'h0000,1'b0,1'b1,1'b0);
        set_vec(25, 1'b0,1'b1,1'b0,16'h0000,1'b0,1'b0,1'b0);
        set_vec(26, 1'b0,1'b0,1'b0,16'h0000,1'b0,1'b0,1'b0);
        set_vec(27, 1'b0,1'b0,1'b0,16'h0000,1'b0,1'b0,1'b0);

        // Reset for one cycle
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        chk("reset count", 32'(count), 32'h0000);
        chk("reset acks", 32'({ackInc, ackDec}), 32'd0);
        chk("reset wrapped", 32'(wrapped), 32'd0);

        // Cycle-by-cycle vector table
        for (int i = 0; i < 28; i++) begin
            incPressed = vecs[i].inc;
            decPressed = vecs[i].dec;
            clear      = vecs[i].clr;
            @(posedge clock);
            @(negedge clock);
            chk($sformatf("vec%0d count", i), 32'(count), 32'(vecs[i].exp_count));
            chk($sformatf("vec%0d ackInc", i), 32'(ackInc), 32'(vecs[i].exp_ai));
            chk($sformatf("vec%0d ackDec", i), 32'(ackDec), 32'(vecs[i].exp_ad));
            chk($sformatf("vec%0d wrapped", i), 32'(wrapped), 32'(vecs[i].exp_w));
        end
        incPressed = 1'b0;
        decPressed = 1'b0;
        clear      = 1'b0;
        m_count    = 0;

        // Carry, borrow and wrap through full handshakes
        for (int i = 0; i < 99; i++) press(1'b1, 1'b0);
        chk("reach 0099", 32'(count), 32'h0099);
        press(1'b1, 1'b0);
        chk("carry 0100", 32'(count), 32'h0100);
        press(1'b0, 1'b1);
        chk("borrow 0099", 32'(count), 32'h0099);
        for (int i = 0; i < 99; i++) press(1'b0, 1'b1);
        chk("down to 0000", 32'(count), 32'h0000);
        press(1'b0, 1'b1);
        chk("dec wrap 9999", 32'(count), 32'h9999);
        press(1'b1, 1'b0);
        chk("inc wrap 0000", 32'(count), 32'h0000);

        // Ten rapid presses from 0005
        for (int i = 0; i < 5; i++) press(1'b1, 1'b0);
        chk("reach 0005", 32'(count), 32'h0005);
        ack_pulses = 0;
        for (int i = 0; i < 10; i++) press(1'b1, 1'b0);
        chk("rapid count", 32'(count), 32'h0015);
        chk("rapid acks", 32'(ack_pulses), 32'd10);

        // Simultaneous requests at 0042
        for (int i = 0; i < 27; i++) press(1'b1, 1'b0);
        chk("reach 0042", 32'(count), 32'h0042);
        press(1'b1, 1'b1);

        // Clear coinciding with an increment at 0123
        for (int i = 0; i < 81; i++) press(1'b1, 1'b0);
        chk("reach 0123", 32'(count), 32'h0123);
        incPressed = 1'b1;
        clear      = 1'b1;
        @(posedge clock);
        @(negedge clock);
        chk("clear count", 32'(count), 32'h0000);
        chk("clear ackInc", 32'(ackInc), 32'd1);
        chk("clear wrapped", 32'(wrapped), 32'd0);
        clear      = 1'b0;
        incPressed = 1'b0;
        m_count    = 0;
        @(posedge clock);
        @(negedge clock);
        @(posedge clock);
        @(negedge clock);

        // Asynchronous reset while in ACK
        incPressed = 1'b1;
        @(posedge clock);
        @(negedge clock);
        chk("pre-reset ackInc", 32'(ackInc), 32'd1);
        chk("pre-reset count", 32'(count), 32'h0001);
        #2;
        reset = 1'b1;
        #1;
        chk("async reset ackInc", 32'(ackInc), 32'd0);
        chk("async reset count", 32'(count), 32'h0000);
        incPressed = 1'b0;
        @(posedge clock);
        @(negedge clock);
        reset   = 1'b0;
        m_count = 0;
        press(1'b1, 1'b0);
        chk("post-reset count", 32'(count), 32'h0001);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire
